// File: rtl/framer_pkg.sv
// Shared constants and types for the audio framer and its downstream windower/FFT.
package framer_pkg;

    // Signed Q15 audio sample width.
    localparam int unsigned SampleWidth = 16;

    // Frame length and hop defaults shared with hanning_window_imag.
    localparam int unsigned FrameLen = 256;
    localparam int unsigned FrameHop = 128;
    localparam int unsigned FftLen   = 512;

    // Readout controller states.
    typedef enum logic [0:0] {
        StIdle,
        StRead
    } framer_state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (1-cycle latency).
module frame_ram #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem [Depth];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; contents are undefined until written, the consumer masks them.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_framer.sv
// Buffers a continuous sample stream in a 2N circular RAM and replays overlapping frames of
// N samples, advancing HOP samples per frame, with frame_start/frame_last markers.
module audio_framer
    import framer_pkg::*;
#(
    parameter int unsigned N   = FrameLen,
    parameter int unsigned HOP = FrameHop,
    parameter int unsigned DW  = SampleWidth,
    localparam int unsigned AW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic [DW-1:0] frame_out,
    output logic          frame_out_valid,
    output logic          frame_start,
    output logic          frame_last,
    output logic          busy,
    output logic          overrun
);

    localparam int unsigned FW = $clog2(N + 1);
    localparam int unsigned HW = (HOP > 1) ? $clog2(HOP) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [FW-1:0] FillFull = FW'(N);
    localparam logic [FW-1:0] FillTrig = FW'(N - 1);
    localparam logic [HW-1:0] HopLast  = HW'(HOP - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(N - 1);
    localparam logic [AW-1:0] FrameOfs = AW'(N);

    // Write side.
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] fill_q, fill_d, fill_eff;
    logic [HW-1:0] hop_q, hop_d, hop_eff;
    logic          trigger;

    // Trigger handoff to the readout side.
    logic          trig_q, trig_d;
    logic [AW-1:0] pend_base_q, pend_base_d;
    logic          start_frame;

    // Readout side.
    framer_state_e state_q, state_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    // Output registers.
    logic valid_q, valid_d;
    logic start_q, start_d;
    logic last_q, last_d;
    logic overrun_q, overrun_d;

    // Write pointer, fill/hop counters and trigger detection; a coincident flush makes the
    // accepted sample the first of a fresh history.
    always_comb begin
        fill_eff    = flush ? '0 : fill_q;
        hop_eff     = flush ? '0 : hop_q;
        trigger     = sample_valid && (fill_eff >= FillTrig) && (hop_eff == HopLast);
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_eff;
        hop_d       = hop_eff;
        pend_base_d = pend_base_q;
        if (sample_valid) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_eff != FillFull) begin
                fill_d = fill_eff + FW'(1);
            end
            hop_d = (hop_eff == HopLast) ? '0 : hop_eff + HW'(1);
        end
        // Oldest sample of the frame: N behind the post-write pointer, modulo 2N.
        if (trigger) begin
            pend_base_d = wr_ptr_q + AW'(1) - FrameOfs;
        end
        trig_d = trigger;
    end

    // Readout FSM: N back-to-back reads per frame, retrigger allowed only on the last read.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        rd_base_d   = rd_base_q;
        overrun_d   = overrun_q;
        start_frame = trig_q && !flush;
        unique case (state_q)
            StIdle: begin
                if (start_frame) begin
                    state_d   = StRead;
                    rd_idx_d  = '0;
                    rd_base_d = pend_base_q;
                end
            end
            StRead: begin
                if (rd_idx_q == IdxLast) begin
                    if (start_frame) begin
                        rd_idx_d  = '0;
                        rd_base_d = pend_base_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    // Trigger mid-frame is dropped; the hop phase keeps running.
                    if (start_frame) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read issue and marker generation, aligned with the RAM's one-cycle read latency.
    always_comb begin
        rd_en   = (state_q == StRead);
        rd_addr = rd_base_q + AW'(rd_idx_q);
        valid_d = rd_en;
        start_d = rd_en && (rd_idx_q == '0);
        last_d  = rd_en && (rd_idx_q == IdxLast);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            hop_q       <= '0;
            trig_q      <= 1'b0;
            pend_base_q <= '0;
            state_q     <= StIdle;
            rd_base_q   <= '0;
            rd_idx_q    <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            hop_q       <= hop_d;
            trig_q      <= trig_d;
            pend_base_q <= pend_base_d;
            state_q     <= state_d;
            rd_base_q   <= rd_base_d;
            rd_idx_q    <= rd_idx_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            last_q      <= last_d;
            overrun_q   <= overrun_d;
        end
    end

    frame_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (sample_valid),
        .wr_addr (wr_ptr_q),
        .wr_data (sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Unread RAM contents never leak out: data is forced to 0 outside a valid beat.
    assign frame_out       = valid_q ? rd_data : '0;
    assign frame_out_valid = valid_q;
    assign frame_start     = start_q;
    assign frame_last      = last_q;
    assign busy            = (state_q == StRead) || valid_q;
    assign overrun         = overrun_q;

endmodule
